// File: rtl/ttl_reg_pipe.sv
// Parametrised '374-style register pipeline: DEPTH stages of WIDTH bits with shift/load/clear,
// per-stage valid tracking and a selectable output tap. Optional macro: TTL_REG_PIPE_TRISTATE_EN.

module ttl_reg_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             nRESET,
    input  logic             ce_i,
    input  logic [1:0]       mode_i,
    input  logic             sel_hit_i,
    input  logic [WIDTH-1:0] sh_data_i,
    input  logic             sh_vld_i,
    input  logic [WIDTH-1:0] ld_data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             vld_d_o,
    output logic             vld_o
);
    localparam logic [1:0] M_HOLD  = 2'b00;
    localparam logic [1:0] M_SHIFT = 2'b01;
    localparam logic [1:0] M_LOAD  = 2'b10;
    localparam logic [1:0] M_CLEAR = 2'b11;

    logic [WIDTH-1:0] data_q, data_d;
    logic             vld_q,  vld_d;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (ce_i) begin
            case (mode_i)
                M_HOLD: ;
                M_SHIFT: begin
                    data_d = sh_data_i;
                    vld_d  = sh_vld_i;
                end
                M_LOAD: begin
                    if (sel_hit_i) begin
                        data_d = ld_data_i;
                        vld_d  = 1'b1;
                    end
                end
                M_CLEAR: begin
                    data_d = '0;
                    vld_d  = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign data_o  = data_q;
    assign vld_d_o = vld_d;
    assign vld_o   = vld_q;
endmodule

module ttl_reg_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int SELW  = $clog2(DEPTH),
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             nRESET,
    input  logic             CE,
    input  logic [1:0]       MODE,
    input  logic [SELW-1:0]  SEL,
    input  logic [WIDTH-1:0] D,
    input  logic [SELW-1:0]  TAP,
    input  logic             nOE,
    output logic [WIDTH-1:0] Q,
    output logic             QV,
    output logic [CNTW-1:0]  COUNT,
    output logic             OVF
);
    localparam logic [1:0] M_SHIFT = 2'b01;

    logic [DEPTH-1:0][WIDTH-1:0] stage;
    logic [DEPTH-1:0]            vld, vld_d;
    logic [CNTW-1:0]             count_q, count_d;
    logic                        ovf_q, ovf_d;

    // Stage 0 shifts in D as valid; stage i shifts in stage i-1.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] sh_data;
        logic             sh_vld;
        if (i == 0) begin : g_head
            assign sh_data = D;
            assign sh_vld  = 1'b1;
        end else begin : g_body
            assign sh_data = stage[i-1];
            assign sh_vld  = vld[i-1];
        end

        ttl_reg_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .CLK       (CLK),
            .nRESET    (nRESET),
            .ce_i      (CE),
            .mode_i    (MODE),
            .sel_hit_i (int'(SEL) == i),
            .sh_data_i (sh_data),
            .sh_vld_i  (sh_vld),
            .ld_data_i (D),
            .data_o    (stage[i]),
            .vld_d_o   (vld_d[i]),
            .vld_o     (vld[i])
        );
    end

    // COUNT is registered from next-state valid bits so it tracks valid[] exactly.
    always_comb begin
        count_d = '0;
        for (int i = 0; i < DEPTH; i++)
            count_d = count_d + CNTW'(vld_d[i]);
        ovf_d = CE && (MODE == M_SHIFT) && vld[DEPTH-1];
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign COUNT = count_q;
    assign OVF   = ovf_q;

    logic [WIDTH-1:0] tap_data;
    logic             tap_vld;

    always_comb begin
        tap_data = '0;
        tap_vld  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(TAP) == i) begin
                tap_data = stage[i];
                tap_vld  = vld[i];
            end
        end
    end

`ifdef TTL_REG_PIPE_TRISTATE_EN
    assign Q  = nOE ? {WIDTH{1'bz}} : tap_data;
    assign QV = nOE ? 1'bz : tap_vld;
`else
    // Output is always driven for FPGA-internal use; nOE has no effect.
    logic unused_noe;
    assign unused_noe = nOE;
    assign Q  = tap_data;
    assign QV = tap_vld;
`endif
endmodule

// File: tb/tb_ttl_reg_pipe.sv
// Directed self-checking bench for ttl_reg_pipe (WIDTH=8, DEPTH=4).

module tb_ttl_reg_pipe;
    logic       CLK = 1'b0;
    logic       nRESET;
    logic       CE;
    logic [1:0] MODE;
    logic [1:0] SEL;
    logic [7:0] D;
    logic [1:0] TAP;
    logic       nOE;
    logic [7:0] Q;
    logic       QV;
    logic [2:0] COUNT;
    logic       OVF;

    int vectors = 0;
    int miscompares = 0;

    ttl_reg_pipe #(.WIDTH(8), .DEPTH(4)) dut (
        .CLK(CLK), .nRESET(nRESET), .CE(CE), .MODE(MODE), .SEL(SEL), .D(D),
        .TAP(TAP), .nOE(nOE), .Q(Q), .QV(QV), .COUNT(COUNT), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRESET = 1'b0; CE = 1'b0; MODE = 2'b00; SEL = '0; D = '0; TAP = '0; nOE = 1'b0;
        #3;
        vectors++; if (Q !== 8'h00) begin miscompares++; $display("FAIL reset_q got %h want 00", Q); end
        vectors++; if (QV !== 1'b0) begin miscompares++; $display("FAIL reset_qv got %b want 0", QV); end
        vectors++; if (COUNT !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", COUNT); end
        vectors++; if (OVF !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b want 0", OVF); end
        nOE = 1'b1; #1;
`ifdef TTL_REG_PIPE_TRISTATE_EN
        vectors++; if (Q !== 8'hzz) begin miscompares++; $display("FAIL reset_q_noe got %h want zz", Q); end
`else
        vectors++; if (Q !== 8'h00) begin miscompares++; $display("FAIL reset_q_noe got %h want 00", Q); end
`endif
        nOE = 1'b0;
        step();
        nRESET = 1'b1;
    endtask

    task automatic test_shift_fill();
        logic [7:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        CE = 1'b1; MODE = 2'b01;
        for (int i = 0; i < 4; i++) begin
            D = words[i];
            step();
            vectors++; if (COUNT !== 3'(i + 1)) begin miscompares++; $display("FAIL fill_count%0d got %0d want %0d", i, COUNT, i + 1); end
            vectors++; if (OVF !== 1'b0) begin miscompares++; $display("FAIL fill_ovf%0d got %b want 0", i, OVF); end
            TAP = 2'd0; #1;
            vectors++; if (Q !== words[i]) begin miscompares++; $display("FAIL fill_tap0_%0d got %h want %h", i, Q, words[i]); end
        end
        MODE = 2'b00;
        TAP = 2'd3; #1;
        vectors++; if (Q !== 8'h11 || QV !== 1'b1) begin miscompares++; $display("FAIL fill_tap3 got %h/%b want 11/1", Q, QV); end
        TAP = 2'd0; #1;
        vectors++; if (Q !== 8'h44 || QV !== 1'b1) begin miscompares++; $display("FAIL fill_tap0 got %h/%b want 44/1", Q, QV); end
    endtask

    task automatic test_back_to_back();
        MODE = 2'b01; D = 8'h55; TAP = 2'd3;
        step();
        vectors++; if (OVF !== 1'b1) begin miscompares++; $display("FAIL ovf_first got %b want 1", OVF); end
        vectors++; if (Q !== 8'h22) begin miscompares++; $display("FAIL ovf_tap3 got %h want 22", Q); end
        vectors++; if (COUNT !== 3'd4) begin miscompares++; $display("FAIL ovf_count got %0d want 4", COUNT); end
        D = 8'h66;
        step();
        vectors++; if (OVF !== 1'b1) begin miscompares++; $display("FAIL ovf_b2b got %b want 1", OVF); end
        vectors++; if (Q !== 8'h33) begin miscompares++; $display("FAIL ovf_b2b_tap3 got %h want 33", Q); end
        MODE = 2'b00;
        step();
        vectors++; if (OVF !== 1'b0) begin miscompares++; $display("FAIL ovf_drop got %b want 0", OVF); end
        vectors++; if (COUNT !== 3'd4) begin miscompares++; $display("FAIL hold_count got %0d want 4", COUNT); end
    endtask

    task automatic test_clear_load();
        MODE = 2'b11;
        step();
        TAP = 2'd0; #1;
        vectors++; if (COUNT !== 3'd0) begin miscompares++; $display("FAIL clear_count got %0d want 0", COUNT); end
        vectors++; if (Q !== 8'h00 || QV !== 1'b0) begin miscompares++; $display("FAIL clear_tap0 got %h/%b want 00/0", Q, QV); end
        MODE = 2'b10; SEL = 2'd2; D = 8'hA5;
        step();
        MODE = 2'b00;
        TAP = 2'd2; #1;
        vectors++; if (Q !== 8'hA5 || QV !== 1'b1) begin miscompares++; $display("FAIL load_tap2 got %h/%b want a5/1", Q, QV); end
        TAP = 2'd1; #1;
        vectors++; if (QV !== 1'b0) begin miscompares++; $display("FAIL load_tap1_qv got %b want 0", QV); end
        vectors++; if (COUNT !== 3'd1) begin miscompares++; $display("FAIL load_count got %0d want 1", COUNT); end
        vectors++; if (OVF !== 1'b0) begin miscompares++; $display("FAIL load_ovf got %b want 0", OVF); end
    endtask

    task automatic test_ce_hold();
        CE = 1'b0; MODE = 2'b01; D = 8'h99; TAP = 2'd2;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (Q !== 8'hA5 || QV !== 1'b1) begin miscompares++; $display("FAIL ce_tap2_%0d got %h/%b want a5/1", i, Q, QV); end
            vectors++; if (COUNT !== 3'd1 || OVF !== 1'b0) begin miscompares++; $display("FAIL ce_cnt_ovf_%0d got %0d/%b want 1/0", i, COUNT, OVF); end
        end
        nOE = 1'b1; #1;
`ifdef TTL_REG_PIPE_TRISTATE_EN
        vectors++; if (Q !== 8'hzz || QV !== 1'bz) begin miscompares++; $display("FAIL noe_high got %h/%b want zz/z", Q, QV); end
`else
        vectors++; if (Q !== 8'hA5 || QV !== 1'b1) begin miscompares++; $display("FAIL noe_high got %h/%b want a5/1", Q, QV); end
`endif
        nOE = 1'b0; #1;
        vectors++; if (Q !== 8'hA5 || QV !== 1'b1) begin miscompares++; $display("FAIL noe_low got %h/%b want a5/1", Q, QV); end
    endtask

    // Shift after a lone load: valid[3] (pre-shift) comes from the loaded stage 2.
    task automatic test_shift_sparse();
        CE = 1'b1; MODE = 2'b01; D = 8'h12;
        step();
        vectors++; if (COUNT !== 3'd2 || OVF !== 1'b0) begin miscompares++; $display("FAIL sparse1 got %0d/%b want 2/0", COUNT, OVF); end
        TAP = 2'd3; #1;
        vectors++; if (Q !== 8'hA5 || QV !== 1'b1) begin miscompares++; $display("FAIL sparse1_tap3 got %h/%b want a5/1", Q, QV); end
        D = 8'hAB;
        step();
        vectors++; if (COUNT !== 3'd2 || OVF !== 1'b1) begin miscompares++; $display("FAIL sparse2 got %0d/%b want 2/1", COUNT, OVF); end
        TAP = 2'd1; #1;
        vectors++; if (Q !== 8'h12 || QV !== 1'b1) begin miscompares++; $display("FAIL sparse2_tap1 got %h/%b want 12/1", Q, QV); end
    endtask

    task automatic test_async_reset();
        MODE = 2'b01; D = 8'hEE; TAP = 2'd1;
        step();
        #2 nRESET = 1'b0;
        #1;
        vectors++; if (COUNT !== 3'd0 || OVF !== 1'b0) begin miscompares++; $display("FAIL arst_cnt_ovf got %0d/%b want 0/0", COUNT, OVF); end
        vectors++; if (Q !== 8'h00 || QV !== 1'b0) begin miscompares++; $display("FAIL arst_q got %h/%b want 00/0", Q, QV); end
        step();
        vectors++; if (COUNT !== 3'd0 || Q !== 8'h00) begin miscompares++; $display("FAIL arst_edge got %0d/%h want 0/00", COUNT, Q); end
        #2 nRESET = 1'b1;
        D = 8'hCD; TAP = 2'd0;
        step();
        vectors++; if (COUNT !== 3'd1 || Q !== 8'hCD || OVF !== 1'b0) begin miscompares++; $display("FAIL arst_release got %0d/%h/%b want 1/cd/0", COUNT, Q, OVF); end
    endtask

    initial begin
        test_reset();
        test_shift_fill();
        test_back_to_back();
        test_clear_load();
        test_ce_hold();
        test_shift_sparse();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
